// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between ALU and load results, one grant per cycle, registered write.
// Define WB_FAIRNESS_EN for ALU anti-starvation (counter + PRIO_ALU); otherwise mem always wins.
module regfile_wb_arbiter #(
   parameter int WIDTH        = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [WIDTH-1:0]      alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0]      mem_data,
   output logic                  mem_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [WIDTH-1:0]      w_data_reg_file,
   output logic                  alu_starved
);

   typedef enum logic {
      PRIO_MEM = 1'b0,
      PRIO_ALU = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic                    grant_alu, grant_mem;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
   logic [WIDTH-1:0]        w_data_q, w_data_d;
   logic                    alu_starved_q, alu_starved_d;

   generate
      if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
         $error("STARVE_LIMIT must be in 1..15");
      end
   endgenerate

`ifdef WB_FAIRNESS_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0]            starve_cnt_q, starve_cnt_d;
`endif

   always_comb begin
      grant_alu = alu_valid && (!mem_valid || (state_q == PRIO_ALU));
      grant_mem = mem_valid && !grant_alu;
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   // x0 writes are still granted so the requester retires them, but never reach the file.
   always_comb begin
      we_d     = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      if (grant_alu) begin
         we_d     = (alu_addr != '0);
         w_addr_d = alu_addr;
         w_data_d = alu_data;
      end else if (grant_mem) begin
         we_d     = (mem_addr != '0);
         w_addr_d = mem_addr;
         w_data_d = mem_data;
      end
   end

   always_comb begin
      state_d       = state_q;
      alu_starved_d = 1'b0;
`ifdef WB_FAIRNESS_EN
      starve_cnt_d = '0;
      if (alu_valid && !grant_alu) begin
         starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
      end
      alu_starved_d = (starve_cnt_d == LIMIT);
      case (state_q)
         PRIO_MEM: if (starve_cnt_d == LIMIT) state_d = PRIO_ALU;
         PRIO_ALU: if (grant_alu)             state_d = PRIO_MEM;
         default:                             state_d = PRIO_MEM;
      endcase
`else
      state_d = PRIO_MEM;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= PRIO_MEM;
         we_q          <= 1'b0;
         w_addr_q      <= '0;
         w_data_q      <= '0;
         alu_starved_q <= 1'b0;
`ifdef WB_FAIRNESS_EN
         starve_cnt_q  <= '0;
`endif
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         w_addr_q      <= w_addr_d;
         w_data_q      <= w_data_d;
         alu_starved_q <= alu_starved_d;
`ifdef WB_FAIRNESS_EN
         starve_cnt_q  <= starve_cnt_d;
`endif
      end
   end

   assign we              = we_q;
   assign w_addr          = w_addr_q;
   assign w_data_reg_file = w_data_q;
   assign alu_starved     = alu_starved_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then constrained-random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
   localparam int WIDTH      = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int LIMIT      = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  alu_valid, mem_valid;
   logic [ADDR_WIDTH-1:0] alu_addr, mem_addr;
   logic [WIDTH-1:0]      alu_data, mem_data;
   logic                  alu_ready, mem_ready;
   logic                  we, alu_starved;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [WIDTH-1:0]      w_data_reg_file;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: ALU losses in a row, and whether the ALU is owed the next collision.
   int                    m_losses = 0;
   bit                    m_owed   = 1'b0;
   bit                    m_we     = 1'b0;
   bit                    m_starved = 1'b0;
   logic [ADDR_WIDTH-1:0] m_addr   = '0;
   logic [WIDTH-1:0]      m_data   = '0;
   bit                    last_ar, last_mr;

   regfile_wb_arbiter #(
      .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .we(we), .w_addr(w_addr), .w_data_reg_file(w_data_reg_file), .alu_starved(alu_starved)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_losses  = 0;
      m_owed    = 1'b0;
      m_we      = 1'b0;
      m_starved = 1'b0;
      m_addr    = '0;
      m_data    = '0;
   endtask

   // Entered and left at posedge+1: drive, check grant, predict, clock, check write port.
   task automatic step(input bit av, input logic [ADDR_WIDTH-1:0] aa, input logic [WIDTH-1:0] ad,
                       input bit mv, input logic [ADDR_WIDTH-1:0] ma, input logic [WIDTH-1:0] md);
      bit ar, mr;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      #1;
      ar = av && (!mv || m_owed);
      mr = mv && !ar;
      check("alu_ready", 32'(alu_ready), 32'(ar));
      check("mem_ready", 32'(mem_ready), 32'(mr));
      last_ar = ar;
      last_mr = mr;
      if (ar) begin
         m_we = (aa != 0); m_addr = aa; m_data = ad;
      end else if (mr) begin
         m_we = (ma != 0); m_addr = ma; m_data = md;
      end else begin
         m_we = 1'b0;
      end
`ifdef WB_FAIRNESS_EN
      if (av && !ar) m_losses = (m_losses >= LIMIT) ? LIMIT : m_losses + 1;
      else           m_losses = 0;
      if (m_owed && ar)                      m_owed = 1'b0;
      else if (!m_owed && m_losses == LIMIT) m_owed = 1'b1;
      m_starved = (m_losses == LIMIT);
`endif
      @(posedge clk);
      #1;
      check("we", 32'(we), 32'(m_we));
      check("w_addr", 32'(w_addr), 32'(m_addr));
      check("w_data", w_data_reg_file, m_data);
      check("alu_starved", 32'(alu_starved), 32'(m_starved));
   endtask

   initial begin
      bit                    pa, pm, av, mv;
      logic [ADDR_WIDTH-1:0] aa, ma;
      logic [WIDTH-1:0]      ad, md;

      // Reset with both requesters valid: mem wins, nothing written.
      rst = 1'b1;
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1;
      mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h2;
      #1;
      check("rst_alu_ready", 32'(alu_ready), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd1);
      check("rst_we", 32'(we), 32'd0);
      check("rst_alu_starved", 32'(alu_starved), 32'd0);
      @(posedge clk);
      #1;
      check("rst_we_held", 32'(we), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      rst = 1'b0;
      model_reset();
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Single ALU write.
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      check("alu_single_we", 32'(we), 32'd1);
      check("alu_single_data", w_data_reg_file, 32'hDEADBEEF);

      // Collision: r7 first, then r8.
      step(1, 5'd8, 32'h22, 1, 5'd7, 32'h11);
      check("coll_addr1", 32'(w_addr), 32'd7);
      step(1, 5'd8, 32'h22, 0, 0, 0);
      check("coll_addr2", 32'(w_addr), 32'd8);
      check("coll_data2", w_data_reg_file, 32'h22);

      // x0 write is accepted but suppressed.
      step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      check("x0_we", 32'(we), 32'd0);
      step(0, 0, 0, 0, 0, 0);

      // Sustained loads against a waiting ALU request.
      for (int i = 0; i < 7; i++) begin
         step(1, 5'd9, 32'hA1A1, 1, 5'(10 + i), 32'h100 + 32'(i));
      end
`ifdef WB_FAIRNESS_EN
      check("starve_alu_won_at_5th", 32'(m_owed), 32'd0);
`else
      check("strict_mem_still_wins", 32'(last_mr), 32'd1);
`endif
      step(0, 0, 0, 0, 0, 0);

      // Async reset mid-starvation, asserted between edges.
      for (int i = 0; i < LIMIT; i++) begin
         step(1, 5'd12, 32'hBEEF, 1, 5'(20 + i), 32'h200 + 32'(i));
      end
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_we", 32'(we), 32'd0);
      check("async_rst_starved", 32'(alu_starved), 32'd0);
      check("async_rst_w_addr", 32'(w_addr), 32'd0);
      model_reset();
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1, 5'd12, 32'hBEEF, 1, 5'd21, 32'h300);
      check("post_rst_mem_first", 32'(last_mr), 32'd1);
      for (int i = 0; i < LIMIT + 1; i++) begin
         step(1, 5'd12, 32'hBEEF, 1, 5'(22 + i), 32'h301 + 32'(i));
      end
      step(0, 0, 0, 0, 0, 0);

      // Random traffic; a refused request is held stable until accepted.
      pa = 1'b0; pm = 1'b0;
      av = 1'b0; mv = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pa) begin
            av = ($urandom_range(0, 99) < 60);
            aa = 5'($urandom_range(0, 31));
            ad = $urandom;
         end
         if (!pm) begin
            mv = ($urandom_range(0, 99) < 70);
            ma = 5'($urandom_range(0, 31));
            md = $urandom;
         end
         step(av, aa, ad, mv, ma, md);
         pa = av && !last_ar;
         pm = mv && !last_mr;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU/immediate results and load/memory results.
- Accepts requests over valid/ready handshakes and picks one per cycle.
- Drives a registered write (we, w_addr, w_data_reg_file) straight into the register file.
- Drops writes to x0 and keeps the ALU path from starving behind a stream of loads.

Parameters:
- WIDTH, 32, data width of the register file.
- ADDR_WIDTH, 5, register address width.
- STARVE_LIMIT, 4, consecutive cycles an ALU request may lose arbitration before it is forced through (valid range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_addr  in  ADDR_WIDTH  load destination register.
- mem_data  in  WIDTH  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- we  out  1  register file write enable (registered).
- w_addr  out  ADDR_WIDTH  register file write address (registered).
- w_data_reg_file  out  WIDTH  register file write data (registered).
- alu_starved  out  1  high while the starvation counter equals STARVE_LIMIT (registered).

Behaviour:
- Reset (async, rst=1): we=0, w_addr=0, w_data_reg_file=0, alu_starved=0, starve_cnt=0, state=PRIO_MEM. Effect is immediate. Any request in flight when rst asserts is lost; requesters must re-present it.
- States:
  - PRIO_MEM: mem wins when both are valid.
  - PRIO_ALU: alu wins when both are valid.
- Grant, within one cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the current state's priority decides.
  - ready is asserted only for the granted requester; at most one ready is high per cycle.
- Acceptance:
  - A handshake is valid & ready in the same cycle.
  - On the next rising edge: w_addr and w_data_reg_file take the granted address and data.
  - we = 1 unless the granted address is 0.
- Latency: one cycle from handshake to we at the register file.
- No grant in a cycle: we=0; w_addr and w_data_reg_file hold their previous values.
- x0 writes are accepted (ready=1) but produce we=0. They still count as a grant for starvation purposes.
- starve_cnt:
  - Increments when alu_valid=1 and alu is not granted; saturates at STARVE_LIMIT.
  - Clears when alu is granted or alu_valid=0.
- Transitions:
  - PRIO_MEM -> PRIO_ALU on the edge where starve_cnt reaches STARVE_LIMIT.
  - PRIO_ALU -> PRIO_MEM on the edge after an ALU grant.
- Ordering: no ordering between the two requesters. Issue logic guarantees the two paths never hold the same destination register at the same time.
- Requester inputs must stay stable while valid=1 and ready=0. The arbiter does not check this.

Optional Feature:
- Macro: WB_FAIRNESS_EN.
- Defined: starvation counter, PRIO_ALU state and alu_starved behave as specified above.
- Undefined: strict fixed priority. mem always wins, state is permanently PRIO_MEM, starve_cnt is absent, and alu_starved is tied to 0.

Test Plan:
- Reset: hold rst=1 with both valid -> we=0, alu_starved=0, and both ready follow the PRIO_MEM grant rule; release rst, idle inputs -> we stays 0.
- Single ALU: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF, mem idle -> alu_ready=1 that cycle; next cycle we=1, w_addr=5, w_data_reg_file=0xDEADBEEF.
- Collision: both valid, mem_addr=7/0x11, alu_addr=8/0x22 -> cycle 1 writes r7=0x11, cycle 2 writes r8=0x22 with alu_ready high in cycle 1 of the ALU grant.
- x0 drop: mem_valid=1, mem_addr=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle we=0.
- Starvation (WB_FAIRNESS_EN, STARVE_LIMIT=4): mem_valid held high with new data each cycle, alu_valid held high -> alu loses 4 cycles, alu_starved=1, ALU granted on the 5th cycle, mem resumes the cycle after. Without the macro, alu is never granted while mem_valid=1.
- Async reset mid-stream: assert rst between clock edges during the starvation sequence -> we, alu_starved and the counter clear immediately; after release, the first collision grants mem.
